// File: rtl/param_datapath_if.sv
// Control-side bundle for param_datapath: bus/register controls, memory and IO data,
// ALU handshake and observation outputs.
interface param_datapath_if #(
  parameter int WIDTH = 32,
  parameter int NREGS = 16
);
  localparam int SW = $clog2(NREGS + 8);
  localparam int RW = $clog2(NREGS);

  logic [SW-1:0]    bus_src;
  logic             reg_wr_en;
  logic [RW-1:0]    reg_wr_sel;
  logic             pc_en;
  logic             ir_en;
  logic             y_en;
  logic             hi_en;
  logic             lo_en;
  logic             mdr_en;
  logic             mdr_read;
  logic [WIDTH-1:0] mdatain;
  logic [WIDTH-1:0] inport_data;
  logic [3:0]       alu_op;
  // Handshake: alu_start is honoured only while alu_busy is low (FSM idle); alu_busy is
  // high for every cycle a multi-cycle op is iterating; alu_done is high for exactly one
  // cycle right after the edge that wrote Z, and busy is already low in that cycle.
  logic             alu_start;
  logic             alu_busy;
  logic             alu_done;
  logic [1:0]       alu_state;
  logic [WIDTH-1:0] bus_out;
  logic [WIDTH-1:0] ir_out;
  logic [WIDTH-1:0] mdr_out;

  modport master (
    output bus_src, reg_wr_en, reg_wr_sel, pc_en, ir_en, y_en, hi_en, lo_en,
           mdr_en, mdr_read, mdatain, inport_data, alu_op, alu_start,
    input  alu_busy, alu_done, alu_state, bus_out, ir_out, mdr_out
  );

  modport slave (
    input  bus_src, reg_wr_en, reg_wr_sel, pc_en, ir_en, y_en, hi_en, lo_en,
           mdr_en, mdr_read, mdatain, inport_data, alu_op, alu_start,
    output alu_busy, alu_done, alu_state, bus_out, ir_out, mdr_out
  );
endinterface

// File: rtl/param_datapath.sv
// Mini SRC datapath: register file, special registers, encoded bus and an ALU with
// single-cycle ops plus iterative signed multiply/divide.
module param_datapath #(
  parameter int WIDTH = 32,
  parameter int NREGS = 16,
  parameter int IMM_W = 19
) (
  input  logic             clk,
  input  logic             clr,
  param_datapath_if.slave  dp
);
  localparam int RW = $clog2(NREGS);
  localparam int AW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2} state_t;

  logic [WIDTH-1:0] regs [NREGS];
  logic [WIDTH-1:0] pc, ir, y, hi, lo, zhi, zlo, mdr;
  logic [WIDTH-1:0] bus, c_val, alu_res, a_mag, b_mag;
  logic [AW-1:0]    sh;
  logic [AW:0]      rsh;
  state_t           state;
  logic             busy, done, neg_q, neg_r;
  logic [AW-1:0]    cnt;
  logic [WIDTH-1:0] opnd, acc_hi, acc_lo, a_lat;

  assign c_val = {{(WIDTH-IMM_W){ir[IMM_W-1]}}, ir[IMM_W-1:0]};

  always_comb begin
    bus = '0;
    if (int'(dp.bus_src) < NREGS) begin
      bus = regs[dp.bus_src[RW-1:0]];
    end else begin
      case (int'(dp.bus_src) - NREGS)
        0:       bus = hi;
        1:       bus = lo;
        2:       bus = zhi;
        3:       bus = zlo;
        4:       bus = pc;
        5:       bus = mdr;
        6:       bus = dp.inport_data;
        7:       bus = c_val;
        default: bus = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      pc  <= '0;
      ir  <= '0;
      y   <= '0;
      hi  <= '0;
      lo  <= '0;
      mdr <= '0;
    end else begin
      if (dp.reg_wr_en) regs[dp.reg_wr_sel] <= bus;
      if (dp.pc_en)     pc <= bus;
      if (dp.ir_en)     ir <= bus;
      if (dp.y_en)      y  <= bus;
      if (dp.hi_en)     hi <= bus;
      if (dp.lo_en)     lo <= bus;
      if (dp.mdr_en)    mdr <= dp.mdr_read ? dp.mdatain : bus;
    end
  end

  // Operands: A is Y, B is the bus; rotates combine two opposite shifts.
  assign sh    = bus[AW-1:0];
  assign rsh   = (AW+1)'(WIDTH) - {1'b0, sh};
  assign a_mag = y[WIDTH-1]   ? -y   : y;
  assign b_mag = bus[WIDTH-1] ? -bus : bus;

  always_comb begin
    alu_res = '0;
    case (dp.alu_op)
      4'd0:    alu_res = y + bus;
      4'd1:    alu_res = y - bus;
      4'd2:    alu_res = y & bus;
      4'd3:    alu_res = y | bus;
      4'd4:    alu_res = y >> sh;
      4'd5:    alu_res = $signed(y) >>> sh;
      4'd6:    alu_res = y << sh;
      4'd7:    alu_res = (y >> sh) | (y << rsh);
      4'd8:    alu_res = (y << sh) | (y >> rsh);
      4'd9:    alu_res = -bus;
      4'd10:   alu_res = ~bus;
      default: alu_res = '0;
    endcase
  end

  // One shift-add step: acc_lo holds the unused multiplier bits, acc_hi the partial sum.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_prod, mul_fix;
  assign mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
  assign mul_prod = {mul_sum, acc_lo[WIDTH-1:1]};
  assign mul_fix  = neg_q ? -mul_prod : mul_prod;

  // One restoring step: acc_hi is the partial remainder, acc_lo shifts dividend out / quotient in.
  logic [WIDTH:0]   div_rs, div_diff;
  logic             div_take;
  logic [WIDTH-1:0] rem_n, quo_n, rem_f, quo_f;
  assign div_rs   = {acc_hi, acc_lo[WIDTH-1]};
  assign div_diff = div_rs - {1'b0, opnd};
  assign div_take = !div_diff[WIDTH];
  assign rem_n    = div_take ? div_diff[WIDTH-1:0] : div_rs[WIDTH-1:0];
  assign quo_n    = {acc_lo[WIDTH-2:0], div_take};
  assign rem_f    = neg_r ? -rem_n : rem_n;
  assign quo_f    = neg_q ? -quo_n : quo_n;

  always_ff @(posedge clk) begin
    if (clr) begin
      state  <= S_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      zhi    <= '0;
      zlo    <= '0;
      cnt    <= '0;
      opnd   <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      a_lat  <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (dp.alu_start) begin
            cnt    <= '0;
            acc_hi <= '0;
            a_lat  <= y;
            neg_q  <= y[WIDTH-1] ^ bus[WIDTH-1];
            neg_r  <= y[WIDTH-1];
            if (dp.alu_op == 4'd11) begin
              state  <= S_MUL;
              busy   <= 1'b1;
              opnd   <= a_mag;
              acc_lo <= b_mag;
            end else if (dp.alu_op == 4'd12) begin
              state  <= S_DIV;
              busy   <= 1'b1;
              opnd   <= b_mag;
              acc_lo <= a_mag;
            end else begin
              zhi  <= '0;
              zlo  <= alu_res;
              done <= 1'b1;
            end
          end
        end
        S_MUL: begin
          {acc_hi, acc_lo} <= mul_prod;
          cnt <= cnt + 1'b1;
          if (cnt == AW'(WIDTH-1)) begin
            {zhi, zlo} <= mul_fix;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        S_DIV: begin
          acc_hi <= rem_n;
          acc_lo <= quo_n;
          cnt    <= cnt + 1'b1;
          if (cnt == AW'(WIDTH-1)) begin
            // A zero divisor reports all-ones quotient and the untouched dividend.
            zlo   <= (opnd == '0) ? '1 : quo_f;
            zhi   <= (opnd == '0) ? a_lat : rem_f;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign dp.bus_out   = bus;
  assign dp.ir_out    = ir;
  assign dp.mdr_out   = mdr;
  assign dp.alu_busy  = busy;
  assign dp.alu_done  = done;
  assign dp.alu_state = state;
endmodule

// File: tb/tb_param_datapath.sv
// Bench for param_datapath: directed transfers plus randomized ALU ops, results checked
// by a done-driven monitor against a queue filled from an arithmetic reference model.
module tb_param_datapath;
  localparam int W     = 32;
  localparam int NREGS = 16;
  localparam int IMM_W = 19;
  localparam int DW    = 2 * W;
  localparam int SW    = $clog2(NREGS + 8);
  localparam int RW    = $clog2(NREGS);
  localparam int C_HI  = NREGS;
  localparam int C_LO  = NREGS + 1;
  localparam int C_ZHI = NREGS + 2;
  localparam int C_ZLO = NREGS + 3;
  localparam int C_PC  = NREGS + 4;
  localparam int C_MDR = NREGS + 5;
  localparam int C_IN  = NREGS + 6;
  localparam int C_C   = NREGS + 7;

  logic clk = 1'b0;
  logic clr = 1'b1;
  int   chk_cnt = 0;
  int   pass_cnt = 0;
  logic [DW-1:0] exp_q[$];

  param_datapath_if #(.WIDTH(W), .NREGS(NREGS)) dif ();
  param_datapath #(.WIDTH(W), .NREGS(NREGS), .IMM_W(IMM_W)) dut (.clk(clk), .clr(clr), .dp(dif));

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic logic [DW-1:0] model(input int op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0]         r;
    logic [DW-1:0]        t;
    logic signed [DW-1:0] sa, sb, q, m;
    int sh;
    sh = int'(b[$clog2(W)-1:0]);
    r  = '0;
    sa = {{W{a[W-1]}}, a};
    sb = {{W{b[W-1]}}, b};
    case (op)
      0:  r = a + b;
      1:  r = a - b;
      2:  r = a & b;
      3:  r = a | b;
      4:  r = a >> sh;
      5:  r = W'($signed(a) >>> sh);
      6:  r = a << sh;
      7:  begin t = {a, a} >> sh; r = t[W-1:0]; end
      8:  begin t = {a, a} << sh; r = t[DW-1:W]; end
      9:  r = -b;
      10: r = ~b;
      11: return sa * sb;
      12: begin
        if (b == '0) return {a, {W{1'b1}}};
        q = sa / sb;
        m = sa % sb;
        return {m[W-1:0], q[W-1:0]};
      end
      default: r = '0;
    endcase
    return {{W{1'b0}}, r};
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return W'(1);
      2:       return '1;
      3:       return {1'b1, {(W-1){1'b0}}};
      4:       return {1'b0, {(W-1){1'b1}}};
      5:       return W'($urandom_range(0, 40));
      default: return W'($urandom());
    endcase
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expected result.
  always @(negedge clk) begin
    if (dif.alu_done === 1'b1) begin
      if (exp_q.size() == 0) chk("unexpected_done", DW'(dif.alu_done), '0);
      else chk("z_result", {dut.zhi, dut.zlo}, exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    dif.bus_src     = '0;
    dif.reg_wr_en   = 1'b0;
    dif.reg_wr_sel  = '0;
    dif.pc_en       = 1'b0;
    dif.ir_en       = 1'b0;
    dif.y_en        = 1'b0;
    dif.hi_en       = 1'b0;
    dif.lo_en       = 1'b0;
    dif.mdr_en      = 1'b0;
    dif.mdr_read    = 1'b0;
    dif.mdatain     = '0;
    dif.inport_data = '0;
    dif.alu_op      = '0;
    dif.alu_start   = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic put(input logic [W-1:0] v);
    dif.bus_src     = SW'(C_IN);
    dif.inport_data = v;
  endtask

  task automatic check_bus(input string name, input int code, input logic [W-1:0] exp);
    dif.bus_src = SW'(code);
    #1;
    chk(name, DW'(dif.bus_out), DW'(exp));
  endtask

  task automatic load_reg(input int idx, input logic [W-1:0] v);
    put(v);
    dif.reg_wr_en  = 1'b1;
    dif.reg_wr_sel = RW'(idx);
    step();
  endtask

  task automatic run_op(input int op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [DW-1:0] e;
    int edges, busy_cycles;
    e = model(op, a, b);
    put(a);
    dif.y_en = 1'b1;
    step();
    put(b);
    dif.alu_op    = 4'(op);
    dif.alu_start = 1'b1;
    exp_q.push_back(e);
    step();
    edges = 1;
    busy_cycles = 0;
    while (dif.alu_done !== 1'b1 && edges < W + 8) begin
      if (dif.alu_busy === 1'b1) busy_cycles++;
      // Noise while busy: stray starts and operand changes must all be ignored.
      put(W'($urandom()));
      dif.alu_op    = 4'($urandom_range(0, 15));
      dif.alu_start = 1'($urandom_range(0, 1));
      dif.y_en      = 1'($urandom_range(0, 1));
      step();
      edges++;
    end
    chk("latency", DW'(edges), DW'((op == 11 || op == 12) ? W + 1 : 1));
    chk("busy_cycles", DW'(busy_cycles), DW'((op == 11 || op == 12) ? W : 0));
    @(negedge clk);
    #1;
    check_bus("zlo_readback", C_ZLO, e[W-1:0]);
    check_bus("zhi_readback", C_ZHI, e[DW-1:W]);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    idle_inputs();
    repeat (2) step();
    clr = 1'b0;
    chk("busy_after_reset", DW'(dif.alu_busy), '0);
    chk("done_after_reset", DW'(dif.alu_done), '0);

    // Reset clears previously loaded state.
    load_reg(3, W'(32'h1234));
    put(W'(5)); dif.pc_en = 1'b1; step();
    check_bus("preload_r3", 3, W'(32'h1234));
    check_bus("preload_pc", C_PC, W'(5));
    clr = 1'b1;
    step();
    clr = 1'b0;
    for (int c = 0; c < NREGS + 8; c++) begin
      if (c != C_IN) check_bus($sformatf("reset_code%0d", c), c, '0);
    end
    chk("reset_busy", DW'(dif.alu_busy), '0);
    chk("reset_done", DW'(dif.alu_done), '0);
    chk("reset_state", DW'(dif.alu_state), '0);

    // Transfer and ADD with operands sourced from registers.
    load_reg(1, W'(32'h22));
    load_reg(2, W'(32'h24));
    dif.bus_src = SW'(1); dif.y_en = 1'b1; step();
    dif.bus_src   = SW'(2);
    dif.alu_op    = 4'd0;
    dif.alu_start = 1'b1;
    exp_q.push_back(model(0, W'(32'h22), W'(32'h24)));
    step();
    chk("add_done", DW'(dif.alu_done), DW'(1));
    @(negedge clk); #1;
    check_bus("add_zlo", C_ZLO, W'(32'h46));
    check_bus("add_zhi", C_ZHI, '0);
    step();

    run_op(7, W'(32'hF), W'(4));
    check_bus("ror_zlo", C_ZLO, W'(32'hF000_0000));

    run_op(11, W'(32'hFFFF_FFF9), W'(6));
    check_bus("mul_zhi", C_ZHI, W'(32'hFFFF_FFFF));
    check_bus("mul_zlo", C_ZLO, W'(32'hFFFF_FFD6));

    run_op(12, W'(32'hFFFF_FFEF), W'(5));
    check_bus("div_q", C_ZLO, W'(32'hFFFF_FFFD));
    check_bus("div_r", C_ZHI, W'(32'hFFFF_FFFE));
    run_op(12, W'(9), W'(0));
    check_bus("div0_q", C_ZLO, W'(32'hFFFF_FFFF));
    check_bus("div0_r", C_ZHI, W'(9));
    run_op(12, W'(32'h8000_0000), W'(32'hFFFF_FFFF));
    check_bus("divov_q", C_ZLO, W'(32'h8000_0000));
    check_bus("divov_r", C_ZHI, '0);

    // Abort a multiply with reset partway through.
    put(W'(32'h1234_5678)); dif.y_en = 1'b1; step();
    put(W'(32'h0000_0777)); dif.alu_op = 4'd11; dif.alu_start = 1'b1; step();
    repeat (8) step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("abort_busy", DW'(dif.alu_busy), '0);
    chk("abort_done", DW'(dif.alu_done), '0);
    chk("abort_state", DW'(dif.alu_state), '0);
    check_bus("abort_zlo", C_ZLO, '0);
    check_bus("abort_zhi", C_ZHI, '0);
    run_op(11, W'(32'h0001_0003), W'(32'hFFFF_0005));

    // MDR from memory and from bus, C sign extension, unused code.
    dif.mdr_read = 1'b1; dif.mdatain = W'(32'hCAFE_BABE); dif.mdr_en = 1'b1; step();
    check_bus("mdr_mem", C_MDR, W'(32'hCAFE_BABE));
    chk("mdr_out", DW'(dif.mdr_out), DW'(W'(32'hCAFE_BABE)));
    put(W'(32'h0BAD_F00D)); dif.mdr_en = 1'b1; step();
    check_bus("mdr_bus", C_MDR, W'(32'h0BAD_F00D));
    put(W'(32'h0004_0000)); dif.ir_en = 1'b1; step();
    check_bus("c_neg", C_C, W'(32'hFFFC_0000));
    chk("ir_out", DW'(dif.ir_out), DW'(W'(32'h0004_0000)));
    put(W'(32'hFFF3_FFFF)); dif.ir_en = 1'b1; step();
    check_bus("c_pos", C_C, W'(32'h0003_FFFF));
    check_bus("invalid_code", NREGS + 8, '0);

    // Several enables share one bus value; old value visible during the write cycle.
    put(W'(32'hA5A5_5A5A));
    dif.pc_en = 1'b1; dif.hi_en = 1'b1; dif.lo_en = 1'b1;
    dif.reg_wr_en = 1'b1; dif.reg_wr_sel = RW'(7);
    step();
    check_bus("multi_pc", C_PC, W'(32'hA5A5_5A5A));
    check_bus("multi_hi", C_HI, W'(32'hA5A5_5A5A));
    check_bus("multi_lo", C_LO, W'(32'hA5A5_5A5A));
    check_bus("multi_r7", 7, W'(32'hA5A5_5A5A));
    load_reg(5, W'(32'h5555));
    dif.bus_src = SW'(5); dif.reg_wr_en = 1'b1; dif.reg_wr_sel = RW'(5); dif.y_en = 1'b1;
    #1;
    chk("read_during_write", DW'(dif.bus_out), DW'(W'(32'h5555)));
    step();

    // Randomized operations.
    for (int n = 0; n < 40; n++) begin
      run_op(int'($urandom_range(0, 15)), pick(), pick());
    end

    repeat (3) step();
    chk("queue_empty", DW'(exp_q.size()), '0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/param_datapath.md
Name: param_datapath

Overview:
- Next-generation Mini SRC datapath with parametrised word width and register count.
- Contains a register file, PC, IR, Y, HI, LO, Z (ZHI/ZLO) and MDR, plus an encoded bus source select.
- Contains an ALU with single-cycle logic/arithmetic and multi-cycle signed multiply and divide engines behind a start/busy/done handshake.
- Sits between the control unit and memory/IO.

Parameters:
WIDTH, 32, datapath word width (even, >=8)
NREGS, 16, general registers R0..R(NREGS-1) (power of 2, >=2)
IMM_W, 19, IR immediate field width; C = sign-extended IR[IMM_W-1:0]

Ports:
clk  in  1  clock, all state updates on rising edge
clr  in  1  synchronous active-high reset
bus_src  in  $clog2(NREGS+8)  bus source code: 0..NREGS-1=Rn, NREGS+0=HI, +1=LO, +2=ZHI, +3=ZLO, +4=PC, +5=MDR, +6=InPort, +7=C
reg_wr_en  in  1  write bus into register reg_wr_sel
reg_wr_sel  in  $clog2(NREGS)  destination register index
pc_en, ir_en, y_en, hi_en, lo_en  in  1 each  load respective register from bus
mdr_en  in  1  load MDR
mdr_read  in  1  MDR source select: 1=mdatain, 0=bus
mdatain  in  WIDTH  memory read data
inport_data  in  WIDTH  input port value
alu_op  in  4  operation code
alu_start  in  1  start pulse, sampled only when not busy
alu_busy  out  1  multi-cycle op in progress
alu_done  out  1  one-cycle pulse: Z just written
bus_out  out  WIDTH  current bus value
ir_out  out  WIDTH  IR contents for the control unit
mdr_out  out  WIDTH  MDR contents for memory write

Behaviour:
- Reset (clr=1 at edge): all registers, Z, HI, LO, MDR, PC, IR, Y = 0; FSM=IDLE; alu_busy=0; alu_done=0. Overrides every enable.
- Reset mid-operation aborts the op. Z is not written and no done pulse.
- Bus is combinational from bus_src. Unused codes (>= NREGS+8) drive 0.
- Register loads take effect at the edge. Same-cycle read of a register being written returns the old value.
- Multiple enables in one cycle all load the same bus value.
- ALU operands: A = Y, B = bus. Shift/rotate amount = B[$clog2(WIDTH)-1:0].
- Ops:
  - 0 ADD, 1 SUB (A-B), 2 AND, 3 OR, 4 SHR (logical), 5 SHRA, 6 SHL, 7 ROR, 8 ROL: single-cycle, ZLO=result, ZHI=0.
  - 9 NEG (-B), 10 NOT (~B): single-cycle, ZLO=result, ZHI=0.
  - 11 MUL: multi-cycle, signed A*B, full 2*WIDTH product, ZHI=upper, ZLO=lower.
  - 12 DIV: multi-cycle, signed A/B, ZLO=quotient (truncated toward zero), ZHI=remainder (sign of dividend).
  - 13-15: single-cycle, Z=0.
- FSM states IDLE, MUL, DIV.
  - IDLE + alu_start + single-cycle op: Z written at that edge; alu_done=1 for the following cycle; stays IDLE.
  - IDLE + alu_start + MUL/DIV: operands latched at that edge; alu_busy=1 next cycle.
    - Iterate WIDTH cycles (shift-add / restoring, magnitudes, sign fixed at end).
    - Z written on the final iteration edge; alu_done pulses 1 cycle; alu_busy drops with done.
    - Start-to-done latency is WIDTH+1 edges.
- alu_start while busy is ignored. Operand changes on bus/Y during busy have no effect.
- Divide by zero: ZLO = all ones, ZHI = dividend; normal latency.
- Overflow case (most-negative / -1): ZLO = most-negative, ZHI = 0.
- ADD/SUB wrap modulo 2^WIDTH; no flags.
- C = {{(WIDTH-IMM_W){IR[IMM_W-1]}}, IR[IMM_W-1:0]}.
- MDR: mdr_en loads mdatain if mdr_read=1, else the bus.

Test Plan:
- Reset: preload R3=0x1234, PC=5, then clr=1 one edge -> all readbacks via bus = 0, alu_busy=0, alu_done=0.
- Transfer/ADD: R1=0x00000022, R2=0x00000024. Y<-R1, bus_src=R2, op ADD start -> next cycle alu_done=1, ZLO=0x46, ZHI=0. ROR by 4 of 0x0000000F -> ZLO=0xF0000000.
- MUL (WIDTH=32): Y=-7, bus=6, start -> alu_busy high 32 cycles, done at edge 33, ZHI=0xFFFFFFFF, ZLO=0xFFFFFFD6. start pulses while busy ignored (result unchanged, single done).
- DIV: Y=-17, bus=5 -> ZLO=0xFFFFFFFD, ZHI=0xFFFFFFFE. Y=9, bus=0 -> ZLO=0xFFFFFFFF, ZHI=9. Y=0x80000000, bus=-1 -> ZLO=0x80000000, ZHI=0.
- Abort: start MUL, assert clr at cycle 10 -> Z=0, no alu_done, FSM IDLE. New start next cycle completes normally.
- MDR/C: mdr_read=1, mdatain=0xCAFEBABE, mdr_en -> bus (MDR)=0xCAFEBABE. IR=0x00040000 -> bus (C)=0xFFFC0000 (IMM_W=19). bus_src=NREGS+8 (invalid) -> bus=0.
